axi_lite_ram_scheduler: RTL and testbench
=========================================

AXI_LITE_RAM_SCHEDULER -- requirements
Module: axi_lite_ram_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, AXI byte-address width; RAM word address is ADDR_WIDTH-2 bits.
REQ-002 i_clk  in  1  single clock; all logic on rising edge.
REQ-003 i_rst  in  1  reset, synchronous, active-high.
REQ-004 i_awvalid/o_awready  in/out  1/1, i_awaddr in ADDR_WIDTH: AXI4-Lite write-address channel.
REQ-005 i_wvalid/o_wready  in/out  1/1, i_wdata in 32, i_wstrb in 4: write-data channel.
REQ-006 o_bvalid out 1, i_bready in 1, o_bresp out 2: write-response channel.
REQ-007 i_arvalid/o_arready  in/out  1/1, i_araddr in ADDR_WIDTH: read-address channel.
REQ-008 o_rvalid out 1, i_rready in 1, o_rdata out 32, o_rresp out 2: read-data channel.
REQ-009 o_ram_en out 1, o_ram_we out 1, o_ram_be out 4, o_ram_addr out ADDR_WIDTH-2, o_ram_wdata out 32: single shared RAM port.
REQ-010 i_ram_rdata  in  32  RAM read data, valid the cycle after a read enable (1-cycle latency).

Function
REQ-011 AW, W, AR each SHALL have a one-entry holding register; ready = holder empty AND matching response (bvalid for AW/W, rvalid for AR) low.
REQ-012 AW and W SHALL be accepted independently, in any order or same cycle; write eligible only when both holders full.
REQ-013 Read eligible when AR holder full.
REQ-014 FSM states: IDLE, WR, RD, RCAP; only IDLE grants.
REQ-015 IDLE: one eligible -> grant it; both eligible -> grant opposite of last_grant; none -> stay IDLE.
REQ-016 last_grant SHALL update on every grant; resets to READ, so first tie goes to write.
REQ-017 WR (1 cycle): o_ram_en=1, o_ram_we=1, o_ram_be=wstrb, o_ram_addr=awaddr[ADDR_WIDTH-1:2], o_ram_wdata=wdata; next: clear AW/W holders, set o_bvalid, IDLE.
REQ-018 RD (1 cycle): o_ram_en=1, o_ram_we=0, o_ram_addr=araddr[ADDR_WIDTH-1:2]; next RCAP.
REQ-019 RCAP: capture i_ram_rdata into o_rdata, clear AR holder, set o_rvalid, IDLE.
REQ-020 Address bits [1:0] SHALL be ignored; no alignment error.
REQ-021 o_bresp and o_rresp SHALL always be 2'b00 (OKAY).
REQ-022 o_bvalid/o_rvalid SHALL hold, with o_rdata stable, until handshake with i_bready/i_rready; clear the cycle after.
REQ-023 Latency, no contention: handshake completing in cycle N -> RAM access cycle N+2 -> valid high cycle N+3 (write) / N+4 (read).
REQ-024 Contention delays the loser by exactly the winner's FSM occupancy (2 cycles for WR, 3 for RD+RCAP).
REQ-025 o_ram_en/o_ram_we SHALL be 0 outside WR/RD; at most one RAM access per cycle.
REQ-026 Write with i_wstrb=4'b0000 SHALL still run WR (o_ram_be=0) and produce a response.

Reset
REQ-027 On i_rst: FSM=IDLE, holders empty, last_grant=READ, o_bvalid=o_rvalid=0, o_rdata=0, o_ram_en=o_ram_we=0, o_ram_be=0.
REQ-028 All readies SHALL be 0 while i_rst high, 1 in the first cycle after release.
REQ-029 Reset mid-transaction SHALL drop it silently: no RAM access, no response afterward.

Structure
REQ-030 Package axi_lite_ram_sched_pkg SHALL hold the FSM state enum, grant enum (WRITE/READ) and RESP_OKAY constant.
REQ-031 One sub-module, axi_lite_chan_hold (parameterised width, one-entry holder with valid/ready and clear), instantiated for AW, W, AR.

Verification
REQ-032 Single write awaddr=7'h0C, wdata=32'h0F0E0D0C, wstrb=4'b0011 -> one WR cycle, o_ram_addr=3, o_ram_be=4'b0011, o_bvalid at N+3, bresp=00.
REQ-033 W one cycle before AW, same data -> no RAM access until AW taken; one write, one response.
REQ-034 Read araddr=7'h10, i_ram_rdata=32'h13121110 -> o_rvalid at N+4, o_rdata=32'h13121110, held 5 cycles with i_rready low.
REQ-035 AW+W+AR same cycle after reset -> write first (o_ram_we=1), read 2 cycles later; repeat -> read-write-read-write alternation.
REQ-036 i_rst asserted in RD state -> no o_rvalid, outputs at reset values, next read completes normally.
REQ-037 o_bvalid pending with i_bready low -> o_awready=o_wready=0 until B handshake; reads still serviced.

Source files
------------

// File: rtl/axi_lite_ram_sched_pkg.sv
// Shared types for the AXI4-Lite to single-port RAM scheduler.
package axi_lite_ram_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RCAP = 2'd3
  } state_e;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_lite_chan_hold.sv
// One-entry holding register for an AXI channel payload; emptied only by i_clear.
module axi_lite_chan_hold #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_block,
  input  logic             i_clear,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Ready is withheld while reset is high and while the matching response is pending.
  assign o_ready = !full_q && !i_block && !i_rst;
  assign o_full  = full_q;
  assign o_data  = data_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (i_clear) begin
      full_d = 1'b0;
    end
    if (i_valid && o_ready) begin
      full_d = 1'b1;
      data_d = i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi_lite_ram_scheduler.sv
// AXI4-Lite slave that serialises writes and reads onto one shared RAM port,
// alternating between the two when both are waiting.
module axi_lite_ram_scheduler
  import axi_lite_ram_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic [1:0]            o_bresp,
  input  logic                  i_arvalid,
  output logic                  o_arready,
  input  logic [ADDR_WIDTH-1:0] i_araddr,
  output logic                  o_rvalid,
  input  logic                  i_rready,
  output logic [31:0]           o_rdata,
  output logic [1:0]            o_rresp,
  output logic                  o_ram_en,
  output logic                  o_ram_we,
  output logic [3:0]            o_ram_be,
  output logic [ADDR_WIDTH-3:0] o_ram_addr,
  output logic [31:0]           o_ram_wdata,
  input  logic [31:0]           i_ram_rdata
);

  localparam int WA = ADDR_WIDTH - 2;

  state_e        state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic          bvalid_q, bvalid_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          aw_full, w_full, ar_full;
  logic [WA-1:0] aw_addr, ar_addr;
  logic [35:0]   w_data;
  logic          aw_clear, w_clear, ar_clear;
  logic          wr_elig, rd_elig;
  logic          ram_en_c, ram_we_c;
  logic [3:0]    ram_be_c;
  logic [WA-1:0] ram_addr_c;
  logic [31:0]   ram_wdata_c;

  // Byte offset within a word carries no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_awaddr[1:0], i_araddr[1:0]};

  axi_lite_chan_hold #(.WIDTH(WA)) u_aw_hold (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_awvalid),
    .o_ready (o_awready),
    .i_data  (i_awaddr[ADDR_WIDTH-1:2]),
    .i_block (bvalid_q),
    .i_clear (aw_clear),
    .o_full  (aw_full),
    .o_data  (aw_addr)
  );

  axi_lite_chan_hold #(.WIDTH(36)) u_w_hold (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_wvalid),
    .o_ready (o_wready),
    .i_data  ({i_wstrb, i_wdata}),
    .i_block (bvalid_q),
    .i_clear (w_clear),
    .o_full  (w_full),
    .o_data  (w_data)
  );

  axi_lite_chan_hold #(.WIDTH(WA)) u_ar_hold (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_arvalid),
    .o_ready (o_arready),
    .i_data  (i_araddr[ADDR_WIDTH-1:2]),
    .i_block (rvalid_q),
    .i_clear (ar_clear),
    .o_full  (ar_full),
    .o_data  (ar_addr)
  );

  assign wr_elig = aw_full && w_full;
  assign rd_elig = ar_full;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    bvalid_d     = bvalid_q && !i_bready;
    rvalid_d     = rvalid_q && !i_rready;
    rdata_d      = rdata_q;
    aw_clear     = 1'b0;
    w_clear      = 1'b0;
    ar_clear     = 1'b0;
    ram_en_c     = 1'b0;
    ram_we_c     = 1'b0;
    ram_be_c     = 4'b0000;
    ram_addr_c   = '0;
    ram_wdata_c  = 32'h0;
    case (state_q)
      ST_IDLE: begin
        // A tie goes to whichever side did not win last time.
        if (wr_elig && (!rd_elig || last_grant_q == GRANT_READ)) begin
          state_d      = ST_WR;
          last_grant_d = GRANT_WRITE;
        end else if (rd_elig) begin
          state_d      = ST_RD;
          last_grant_d = GRANT_READ;
        end
      end
      ST_WR: begin
        ram_en_c    = 1'b1;
        ram_we_c    = 1'b1;
        ram_be_c    = w_data[35:32];
        ram_addr_c  = aw_addr;
        ram_wdata_c = w_data[31:0];
        aw_clear    = 1'b1;
        w_clear     = 1'b1;
        bvalid_d    = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_RD: begin
        ram_en_c   = 1'b1;
        ram_addr_c = ar_addr;
        state_d    = ST_RCAP;
      end
      ST_RCAP: begin
        rdata_d  = i_ram_rdata;
        ar_clear = 1'b1;
        rvalid_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
    end
  end

  // Reset also suppresses an access that would otherwise be in flight this cycle.
  assign o_ram_en    = ram_en_c && !i_rst;
  assign o_ram_we    = ram_we_c && !i_rst;
  assign o_ram_be    = i_rst ? 4'b0000 : ram_be_c;
  assign o_ram_addr  = ram_addr_c;
  assign o_ram_wdata = ram_wdata_c;
  assign o_bvalid    = bvalid_q;
  assign o_rvalid    = rvalid_q;
  assign o_rdata     = rdata_q;
  assign o_bresp     = RESP_OKAY;
  assign o_rresp     = RESP_OKAY;

endmodule

// File: tb/tb_axi_lite_ram_scheduler.sv
// Bench for axi_lite_ram_scheduler: directed timing cases plus randomized traffic
// scored against a word-level memory model.
module tb_axi_lite_ram_scheduler;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_awvalid, i_wvalid, i_arvalid, i_bready, i_rready;
  logic [6:0]  i_awaddr, i_araddr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid;
  logic [1:0]  o_bresp, o_rresp;
  logic [31:0] o_rdata;
  logic        o_ram_en, o_ram_we;
  logic [3:0]  o_ram_be;
  logic [4:0]  o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;

  int n_total = 0;
  int n_bad   = 0;
  logic        mem_init;
  logic [31:0] ram_mem [32];
  logic [31:0] ref_mem [32];

  axi_lite_ram_scheduler #(.ADDR_WIDTH(7)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata), .o_rresp(o_rresp),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_be(o_ram_be),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01030507) ^ 32'hC0DE0000;
  endfunction

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAM with one-cycle read latency.
  always @(posedge i_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= init_word(i);
    end else if (o_ram_en) begin
      if (o_ram_we) begin
        for (int b = 0; b < 4; b++)
          if (o_ram_be[b]) ram_mem[o_ram_addr][8*b +: 8] <= o_ram_wdata[8*b +: 8];
      end else begin
        i_ram_rdata <= ram_mem[o_ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc_nxt();
    @(posedge i_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  task automatic wr_txn(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                        input bit hold_b);
    bit aw_done, w_done, b_done;
    aw_done = 0; w_done = 0; b_done = 0;
    cyc_nxt();
    i_awvalid = 1; i_awaddr = a; i_wvalid = 1; i_wdata = d; i_wstrb = s;
    i_bready = !hold_b;
    for (int k = 0; k < 40 && !b_done; k++) begin
      smp();
      if (i_awvalid && o_awready) aw_done = 1;
      if (i_wvalid && o_wready) w_done = 1;
      if (o_bvalid) begin
        b_done = 1;
        chk("wr_bresp", 32'(o_bresp), 32'h0);
      end
      cyc_nxt();
      if (aw_done) i_awvalid = 0;
      if (w_done) i_wvalid = 0;
    end
    i_bready = 0; i_awvalid = 0; i_wvalid = 0;
    chk("wr_done", 32'(b_done), 32'h1);
    ref_mem[a[6:2]] = merge_word(ref_mem[a[6:2]], d, s);
    $display("write addr=%h data=%h strb=%b", a, d, s);
  endtask

  task automatic rd_txn(input logic [6:0] a);
    bit ar_done, r_done;
    logic [31:0] exp;
    ar_done = 0; r_done = 0;
    exp = ref_mem[a[6:2]];
    cyc_nxt();
    i_arvalid = 1; i_araddr = a; i_rready = 1;
    for (int k = 0; k < 40 && !r_done; k++) begin
      smp();
      if (i_arvalid && o_arready) ar_done = 1;
      if (o_rvalid) begin
        r_done = 1;
        chk("rd_data", o_rdata, exp);
        chk("rd_rresp", 32'(o_rresp), 32'h0);
      end
      cyc_nxt();
      if (ar_done) i_arvalid = 0;
    end
    i_rready = 0; i_arvalid = 0;
    chk("rd_done", 32'(r_done), 32'h1);
    $display("read addr=%h expected=%h", a, exp);
  endtask

  // AW, W and AR presented together; write-first expects WR@+2/RD@+4, read-first RD@+2/WR@+5.
  task automatic tie_round(input bit exp_wr_first);
    logic [6:0]  wa, ra;
    logic [31:0] wd, rexp;
    logic [3:0]  ws;
    int wr_at, rd_at, bv_at, rv_at;
    wa = 7'($urandom); ra = wa ^ 7'h40; wd = $urandom; ws = 4'($urandom);
    rexp = ref_mem[ra[6:2]];
    wr_at = -1; rd_at = -1; bv_at = -1; rv_at = -1;
    cyc_nxt();
    i_awvalid = 1; i_awaddr = wa; i_wvalid = 1; i_wdata = wd; i_wstrb = ws;
    i_arvalid = 1; i_araddr = ra; i_bready = 1; i_rready = 1;
    smp();
    chk("tie_readies", 32'({o_awready, o_wready, o_arready}), 32'h7);
    for (int k = 1; k <= 7; k++) begin
      cyc_nxt();
      i_awvalid = 0; i_wvalid = 0; i_arvalid = 0;
      smp();
      if (o_ram_en && o_ram_we && wr_at < 0) wr_at = k;
      if (o_ram_en && !o_ram_we && rd_at < 0) rd_at = k;
      if (o_bvalid && bv_at < 0) bv_at = k;
      if (o_rvalid && rv_at < 0) begin
        rv_at = k;
        chk("tie_rdata", o_rdata, rexp);
      end
    end
    chk("tie_wr_cycle", 32'(wr_at), exp_wr_first ? 32'd2 : 32'd5);
    chk("tie_rd_cycle", 32'(rd_at), exp_wr_first ? 32'd4 : 32'd2);
    chk("tie_bvalid_cycle", 32'(bv_at), exp_wr_first ? 32'd3 : 32'd6);
    chk("tie_rvalid_cycle", 32'(rv_at), exp_wr_first ? 32'd6 : 32'd4);
    ref_mem[wa[6:2]] = merge_word(ref_mem[wa[6:2]], wd, ws);
    cyc_nxt();
    i_bready = 0; i_rready = 0;
    $display("tie write_first=%0d wr=%h rd=%h wr_at=%0d rd_at=%0d", exp_wr_first, wa, ra, wr_at, rd_at);
  endtask

  // Random-phase bookkeeping
  bit          wr_busy, aw_pend, w_pend, rd_busy, ar_pend;
  bit          aw_hs, w_hs, ar_hs, prev_rv, prev_rr;
  logic [6:0]  wr_a, rd_a;
  logic [31:0] wr_d, rd_exp, prev_rdata;
  logic [3:0]  wr_s;
  int          wr_age, rd_age, wr_cnt, rd_cnt, acc;
  bit          seen_rv;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1; mem_init = 1;
    i_awvalid = 0; i_wvalid = 0; i_arvalid = 0; i_bready = 0; i_rready = 0;
    i_awaddr = 0; i_araddr = 0; i_wdata = 0; i_wstrb = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

    // Reset state
    repeat (2) cyc_nxt();
    smp();
    chk("rst_readies", 32'({o_awready, o_wready, o_arready}), 32'h0);
    chk("rst_valids", 32'({o_bvalid, o_rvalid}), 32'h0);
    chk("rst_ram_en_we", 32'({o_ram_en, o_ram_we}), 32'h0);
    chk("rst_ram_be", 32'(o_ram_be), 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    cyc_nxt();
    i_rst = 0; mem_init = 0;
    smp();
    chk("post_rst_readies", 32'({o_awready, o_wready, o_arready}), 32'h7);

    // Single aligned write, cycle-exact
    cyc_nxt();
    i_awvalid = 1; i_awaddr = 7'h0C; i_wvalid = 1; i_wdata = 32'h0F0E0D0C; i_wstrb = 4'b0011;
    smp();
    cyc_nxt(); i_awvalid = 0; i_wvalid = 0;
    smp(); chk("w1_n1_ram_en", 32'(o_ram_en), 32'h0);
    cyc_nxt(); smp();
    chk("w1_n2_en_we", 32'({o_ram_en, o_ram_we}), 32'h3);
    chk("w1_n2_addr", 32'(o_ram_addr), 32'd3);
    chk("w1_n2_be", 32'(o_ram_be), 32'b0011);
    chk("w1_n2_wdata", o_ram_wdata, 32'h0F0E0D0C);
    cyc_nxt(); smp();
    chk("w1_n3_bvalid", 32'(o_bvalid), 32'h1);
    chk("w1_n3_bresp", 32'(o_bresp), 32'h0);
    chk("w1_n3_ram_en", 32'(o_ram_en), 32'h0);
    chk("w1_n3_aw_w_ready", 32'({o_awready, o_wready}), 32'h0);
    cyc_nxt(); i_bready = 1; smp();
    cyc_nxt(); i_bready = 0; smp();
    chk("w1_b_cleared", 32'(o_bvalid), 32'h0);
    ref_mem[3] = merge_word(ref_mem[3], 32'h0F0E0D0C, 4'b0011);
    $display("write addr=0c data=0f0e0d0c strb=0011");

    // W one cycle ahead of AW, zero byte enables
    acc = 0;
    cyc_nxt(); i_wvalid = 1; i_wdata = 32'hDEADBEEF; i_wstrb = 4'b0000;
    smp(); chk("w2_wready", 32'(o_wready), 32'h1); acc += int'(o_ram_en);
    cyc_nxt(); i_wvalid = 0; i_awvalid = 1; i_awaddr = 7'h2B;
    smp(); chk("w2_wready_full", 32'(o_wready), 32'h0); acc += int'(o_ram_en);
    cyc_nxt(); i_awvalid = 0; smp(); acc += int'(o_ram_en);
    chk("w2_no_early_access", 32'(acc), 32'd0);
    cyc_nxt(); smp(); acc += int'(o_ram_en);
    chk("w2_wr_we_be", 32'({o_ram_we, o_ram_be}), 32'h10);
    chk("w2_wr_addr", 32'(o_ram_addr), 32'd10);
    cyc_nxt(); smp(); acc += int'(o_ram_en);
    chk("w2_bvalid", 32'(o_bvalid), 32'h1);
    cyc_nxt(); i_bready = 1; smp(); acc += int'(o_ram_en);
    cyc_nxt(); i_bready = 0; smp(); acc += int'(o_ram_en);
    chk("w2_one_access", 32'(acc), 32'd1);
    chk("w2_b_cleared", 32'(o_bvalid), 32'h0);
    $display("write addr=2b data=deadbeef strb=0000");

    // Read with response held off for five cycles
    wr_txn(7'h10, 32'h13121110, 4'hF, 0);
    cyc_nxt(); i_araddr = 7'h10; i_arvalid = 1;
    smp(); chk("r1_arready", 32'(o_arready), 32'h1);
    cyc_nxt(); i_arvalid = 0; smp(); chk("r1_n1_ram_en", 32'(o_ram_en), 32'h0);
    cyc_nxt(); smp();
    chk("r1_n2_en_we", 32'({o_ram_en, o_ram_we}), 32'h2);
    chk("r1_n2_addr", 32'(o_ram_addr), 32'd4);
    cyc_nxt(); smp(); chk("r1_n3_rvalid", 32'(o_rvalid), 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc_nxt(); smp();
      chk("r1_hold_rvalid", 32'(o_rvalid), 32'h1);
      chk("r1_hold_rdata", o_rdata, 32'h13121110);
      chk("r1_hold_arready", 32'(o_arready), 32'h0);
    end
    cyc_nxt(); i_rready = 1; smp();
    cyc_nxt(); i_rready = 0; smp();
    chk("r1_r_cleared", 32'(o_rvalid), 32'h0);
    $display("read addr=10 expected=13121110");

    // Arbitration: tie to write, again to write, then a lone write flips the next tie
    tie_round(1);
    tie_round(1);
    wr_txn(7'h05, 32'h0BADF00D, 4'b1010, 0);
    tie_round(0);

    // Pending B response blocks AW/W but not reads
    wr_txn(7'h30, 32'hCAFE1234, 4'b1111, 1);
    smp();
    chk("bhold_bvalid", 32'(o_bvalid), 32'h1);
    chk("bhold_aw_w_ready", 32'({o_awready, o_wready}), 32'h0);
    rd_txn(7'h18);
    smp();
    chk("bhold_after_rd", 32'({o_bvalid, o_awready, o_wready}), 32'h4);
    cyc_nxt(); i_bready = 1; smp();
    cyc_nxt(); i_bready = 0; smp();
    chk("bhold_released", 32'({o_bvalid, o_awready, o_wready}), 32'h3);

    // Reset while in RD drops the read
    cyc_nxt(); i_araddr = 7'h24; i_arvalid = 1;
    smp(); chk("rstrd_arready", 32'(o_arready), 32'h1);
    cyc_nxt(); i_arvalid = 0; smp();
    cyc_nxt(); i_rst = 1; smp();
    chk("rstrd_ram_en", 32'(o_ram_en), 32'h0);
    chk("rstrd_readies", 32'({o_awready, o_wready, o_arready}), 32'h0);
    cyc_nxt(); i_rst = 0; smp();
    chk("rstrd_outputs", 32'({o_rvalid, o_bvalid, o_ram_en, o_ram_we}), 32'h0);
    chk("rstrd_rdata", o_rdata, 32'h0);
    chk("rstrd_readies_back", 32'({o_awready, o_wready, o_arready}), 32'h7);
    seen_rv = 0;
    for (int i = 0; i < 6; i++) begin
      cyc_nxt(); smp();
      seen_rv |= o_rvalid | o_ram_en;
    end
    chk("rstrd_silent", 32'(seen_rv), 32'h0);
    rd_txn(7'h24);

    // Randomized traffic
    wr_busy = 0; aw_pend = 0; w_pend = 0; rd_busy = 0; ar_pend = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; prev_rv = 0; prev_rr = 0; prev_rdata = 0;
    wr_age = 0; rd_age = 0; wr_cnt = 0; rd_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc_nxt();
      if (aw_hs) i_awvalid = 0;
      if (w_hs) i_wvalid = 0;
      if (ar_hs) i_arvalid = 0;
      if (!wr_busy && $urandom_range(3) == 0) begin
        wr_a = 7'($urandom);
        if (rd_busy && wr_a[6:2] == rd_a[6:2]) wr_a ^= 7'h04;
        wr_d = $urandom; wr_s = 4'($urandom);
        wr_busy = 1; aw_pend = 1; w_pend = 1; wr_age = 0;
      end
      if (!rd_busy && $urandom_range(3) == 0) begin
        rd_a = 7'($urandom);
        if (wr_busy && wr_a[6:2] == rd_a[6:2]) rd_a ^= 7'h04;
        rd_exp = ref_mem[rd_a[6:2]];
        rd_busy = 1; ar_pend = 1; rd_age = 0;
      end
      if (aw_pend && !i_awvalid && $urandom_range(1) == 1) begin i_awvalid = 1; i_awaddr = wr_a; end
      if (w_pend && !i_wvalid && $urandom_range(1) == 1) begin
        i_wvalid = 1; i_wdata = wr_d; i_wstrb = wr_s;
      end
      if (ar_pend && !i_arvalid && $urandom_range(1) == 1) begin i_arvalid = 1; i_araddr = rd_a; end
      i_bready = 1'($urandom_range(1));
      i_rready = 1'($urandom_range(1));
      smp();
      aw_hs = i_awvalid && o_awready; if (aw_hs) aw_pend = 0;
      w_hs  = i_wvalid && o_wready;   if (w_hs) w_pend = 0;
      ar_hs = i_arvalid && o_arready; if (ar_hs) ar_pend = 0;
      if (o_ram_we) chk("rand_we_has_en", 32'(o_ram_en), 32'h1);
      if (o_rvalid && prev_rv && !prev_rr) chk("rand_rdata_stable", o_rdata, prev_rdata);
      if (o_bvalid && i_bready) begin
        chk("rand_b_expected", 32'(wr_busy), 32'h1);
        chk("rand_bresp", 32'(o_bresp), 32'h0);
        ref_mem[wr_a[6:2]] = merge_word(ref_mem[wr_a[6:2]], wr_d, wr_s);
        wr_busy = 0; wr_cnt++;
        $display("rand write addr=%h data=%h strb=%b", wr_a, wr_d, wr_s);
      end
      if (o_rvalid && i_rready) begin
        chk("rand_r_expected", 32'(rd_busy), 32'h1);
        chk("rand_rdata", o_rdata, rd_exp);
        chk("rand_rresp", 32'(o_rresp), 32'h0);
        rd_busy = 0; rd_cnt++;
        $display("rand read addr=%h data=%h expected=%h", rd_a, o_rdata, rd_exp);
      end
      if (wr_busy) wr_age++;
      if (rd_busy) rd_age++;
      if (wr_age > 60) begin chk("rand_wr_timeout", 32'h0, 32'h1); wr_busy = 0; wr_age = 0; end
      if (rd_age > 60) begin chk("rand_rd_timeout", 32'h0, 32'h1); rd_busy = 0; rd_age = 0; end
      prev_rv = o_rvalid; prev_rr = i_rready; prev_rdata = o_rdata;
    end
    chk("rand_wr_progress", 32'(wr_cnt > 50), 32'h1);
    chk("rand_rd_progress", 32'(rd_cnt > 50), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
